// File: rtl/usr_serial_tx_if.sv
// rtl/usr_serial_tx_if.sv - parallel-word valid/ready handshake into usr_serial_tx
interface usr_serial_tx_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_dir;

    modport master (output in_valid, in_data, in_dir, input in_ready);
    modport slave  (input in_valid, in_data, in_dir, output in_ready);
endinterface

// File: rtl/usr_serial_tx.sv
// rtl/usr_serial_tx.sv - serial-load driver that shifts a parallel word into a downstream universal shift register
// Optional macro USRTX_CLEAR_EN prepends one mode-11 clear cycle (pd_out=0) to every frame.
module usr_serial_tx #(
    parameter int WIDTH   = 4,
    parameter int BIT_CYC = 1
) (
    input  logic             clk,
    input  logic             rst,
    usr_serial_tx_if.slave   in_if,
    output logic             s1,
    output logic             s0,
    output logic             sl,
    output logic             sr,
    output logic [WIDTH-1:0] pd_out,
    output logic             busy,
    output logic             done
);
    localparam int IW = $clog2(WIDTH + 1);
    localparam int SW = $clog2(BIT_CYC + 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(WIDTH - 1);
    localparam logic [SW-1:0] LAST_SLOT = SW'(BIT_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_STROBE,
        ST_GAP,
        ST_FIN
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] data_q;
    logic             dir_q;
    logic [IW-1:0]    idx_q;
    logic [SW-1:0]    slot_q;
    logic             in_ready_q;
    logic             busy_q;
    logic             done_q;
    logic [1:0]       mode_q;
    logic             sl_q;
    logic             sr_q;

    // {mode, sl, sr} for strobe idx: LSB-first on sr when dir=0, MSB-first on sl when dir=1.
    function automatic logic [3:0] strobe_drive(input logic [WIDTH-1:0] d,
                                                input logic             dir,
                                                input logic [IW-1:0]    idx);
        logic [WIDTH-1:0] sh;
        logic [3:0]       r;
        if (dir) begin
            sh = d << idx;
            r  = {2'b10, sh[WIDTH-1], 1'b0};
        end else begin
            sh = d >> idx;
            r  = {2'b01, 1'b0, sh[0]};
        end
        return r;
    endfunction

    logic [IW-1:0] idx_d;
    logic          last_bit;
    logic [3:0]    next_drive;

    always_comb begin
        idx_d      = idx_q + IW'(1);
        last_bit   = (idx_q == LAST_IDX);
        next_drive = strobe_drive(data_q, dir_q, idx_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            data_q     <= '0;
            dir_q      <= 1'b0;
            idx_q      <= '0;
            slot_q     <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mode_q     <= 2'b00;
            sl_q       <= 1'b0;
            sr_q       <= 1'b0;
        end else begin
            case (state_q)
                // FIN accepts exactly like IDLE so back-to-back frames lose no cycle.
                ST_IDLE, ST_FIN: begin
                    done_q <= 1'b0;
                    if (in_if.in_valid) begin
                        data_q     <= in_if.in_data;
                        dir_q      <= in_if.in_dir;
                        idx_q      <= '0;
                        slot_q     <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
`ifdef USRTX_CLEAR_EN
                        state_q                <= ST_CLEAR;
                        {mode_q, sl_q, sr_q}   <= 4'b1100;
`else
                        state_q                <= ST_STROBE;
                        {mode_q, sl_q, sr_q}   <= strobe_drive(in_if.in_data, in_if.in_dir, '0);
`endif
                    end else begin
                        state_q              <= ST_IDLE;
                        in_ready_q           <= 1'b1;
                        busy_q               <= 1'b0;
                        {mode_q, sl_q, sr_q} <= 4'b0000;
                    end
                end
`ifdef USRTX_CLEAR_EN
                ST_CLEAR: begin
                    state_q              <= ST_STROBE;
                    {mode_q, sl_q, sr_q} <= strobe_drive(data_q, dir_q, '0);
                end
`endif
                ST_STROBE: begin
                    if (BIT_CYC > 1) begin
                        state_q              <= ST_GAP;
                        slot_q               <= SW'(1);
                        {mode_q, sl_q, sr_q} <= 4'b0000;
                    end else if (last_bit) begin
                        state_q              <= ST_FIN;
                        done_q               <= 1'b1;
                        busy_q               <= 1'b0;
                        in_ready_q           <= 1'b1;
                        {mode_q, sl_q, sr_q} <= 4'b0000;
                    end else begin
                        idx_q                <= idx_d;
                        {mode_q, sl_q, sr_q} <= next_drive;
                    end
                end
                ST_GAP: begin
                    if (slot_q != LAST_SLOT) begin
                        slot_q <= slot_q + SW'(1);
                    end else if (last_bit) begin
                        state_q              <= ST_FIN;
                        done_q               <= 1'b1;
                        busy_q               <= 1'b0;
                        in_ready_q           <= 1'b1;
                        {mode_q, sl_q, sr_q} <= 4'b0000;
                    end else begin
                        state_q              <= ST_STROBE;
                        idx_q                <= idx_d;
                        {mode_q, sl_q, sr_q} <= next_drive;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_if.in_ready = in_ready_q;
    assign {s1, s0}       = mode_q;
    assign sl             = sl_q;
    assign sr             = sr_q;
    assign busy           = busy_q;
    assign done           = done_q;
    // The clear cycle loads zero, so the parallel bus never carries anything else.
    assign pd_out         = '0;

`ifndef USRTX_CLEAR_EN
    a_no_mode11: assert property (@(posedge clk) disable iff (rst) mode_q != 2'b11);
`endif
    a_ready_busy_excl: assert property (@(posedge clk) disable iff (rst) !(in_ready_q && busy_q));
endmodule

// File: doc/usr_serial_tx.md
Name: usr_serial_tx

Overview:
- Serial-side driver for the 4-bit universal shift register; the transmitting end of its serial-load interface.
- Accepts a parallel word over a valid/ready handshake.
- Emits mode-select strobes (S1,S0) plus serial bits on SL/SR so that a downstream USR, after WIDTH strobes, holds exactly the word.
- Lives beside the USR in the same tile; its outputs map onto the USR's ui_in[3:0] controls.

Parameters:
WIDTH, 4, data word width and number of serial bits per frame (>=2)
BIT_CYC, 1, clock cycles per bit slot: 1 strobe cycle + (BIT_CYC-1) hold cycles (>=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  in_data/in_dir valid
in_ready  output  1  block can accept a frame
in_data  input  WIDTH  word to deliver
in_dir  input  1  0 = shift-right delivery (via sr), 1 = shift-left delivery (via sl)
s1  output  1  mode select MSB to USR
s0  output  1  mode select LSB to USR
sl  output  1  serial-left bit (enters USR Q0)
sr  output  1  serial-right bit (enters USR Q[WIDTH-1])
pd_out  output  WIDTH  parallel-load data to USR; all-zero unless USRTX_CLEAR_EN
busy  output  1  frame in progress
done  output  1  one-cycle pulse at frame completion

Behaviour:
- Interface: one clock clk; synchronous active-high reset rst. All outputs are registered.
- Reset values: in_ready=1, s1=s0=0 (HOLD), sl=sr=0, pd_out=0, busy=0, done=0, bit counter=0, slot counter=0.
- FSM states: IDLE, STROBE, GAP, FIN.
- IDLE:
  - in_ready=1, mode=00.
  - On in_valid&&in_ready at edge k: latch in_data/in_dir, bit index=0, go to STROBE.
  - busy=1 and in_ready=0 from cycle k+1.
- STROBE (exactly 1 cycle per bit):
  - dir=0: {s1,s0}=01 and sr=data[idx]; bits go LSB first (idx 0..WIDTH-1), so data[0] lands in USR Q0.
  - dir=1: {s1,s0}=10 and sl=data[WIDTH-1-idx]; bits go MSB first.
  - The unused serial line is 0.
  - Next state: GAP if BIT_CYC>1; otherwise next STROBE, or FIN after the last bit.
- GAP:
  - BIT_CYC-1 cycles with mode=00 and sl=sr=0.
  - Then next STROBE, or FIN after the last bit.
- FIN (1 cycle):
  - done=1, busy=0, in_ready=1, mode=00.
  - Handshake in FIN behaves as in IDLE, so back-to-back frames have no dead cycle.
  - Next state: STROBE if a frame was accepted, else IDLE.
- Timing: for acceptance at edge k, strobe i occurs in cycle k+1+i*BIT_CYC and done in cycle k+1+WIDTH*BIT_CYC.
- in_data and in_dir are ignored while in_ready=0. The latched copy is immune to input changes mid-frame.
- Mode 11 is never emitted, except under USRTX_CLEAR_EN.
- Reset mid-frame: at the next edge all outputs return to reset values, the frame is discarded, and no done pulse is produced.
- rst and in_valid in the same cycle: reset wins, nothing is accepted.
- Counters: bit index is ceil(log2(WIDTH+1)) bits wide; slot counter is ceil(log2(BIT_CYC+1)) bits wide. Neither counter wraps within a frame.

Optional Feature:
- Macro USRTX_CLEAR_EN.
  - Defined: each frame begins with one extra cycle of {s1,s0}=11 and pd_out=0, clearing the USR before the first STROBE. All strobe and done timings shift by +1 cycle.
  - Undefined: no clear cycle, and pd_out is constant 0.

Test Plan:
1. WIDTH=4, BIT_CYC=1, accept data=4'b1011, dir=0 -> cycles k+1..k+4 show mode=01, sr=1,1,0,1; done at k+5; attached USR model Q=1011.
2. dir=1, data=4'b0110 -> mode=10, sl=0,1,1,0 in four consecutive cycles, sr=0 throughout; USR Q=0110 after done.
3. BIT_CYC=3, data=4'b1001, dir=0 -> strobes at k+1, k+4, k+7, k+10 with two mode=00 cycles between each; done at k+13.
4. in_valid held high with data A=4'hA then B=4'h5 -> B accepted in A's FIN cycle; B's first strobe immediately follows; in_data changes during A have no effect.
5. rst asserted at the third strobe of a frame -> next cycle all outputs at reset values and no done pulse; a new frame is accepted right after rst drops and completes normally.
6. With USRTX_CLEAR_EN and USR preloaded to 4'hF, send 4'b0001 dir=0 -> cycle k+1 mode=11 with pd_out=0; strobes at k+2..k+5; done at k+6; USR Q=0001.
